// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: display, writer and frame-buffer RAM signals of vga_fb_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 24
);
  logic              frame_start;
  logic              pix_rd;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              underflow;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  frame_start, pix_rd, wr_req, wr_addr, wr_data, mem_rdata,
    output pix_valid, pix_data, underflow, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output frame_start, pix_rd, wr_req, wr_addr, wr_data, mem_rdata,
    input  pix_valid, pix_data, underflow, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port frame-buffer RAM between burst display
// prefetch (into a pixel FIFO) and single-word writer accesses.
// Optional build macro FB_ARB_STATS_EN adds saturating underflow_cnt and
// wr_wait_cnt outputs, cleared by reset and by frame_start.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned H_DISPLAY  = 1920,
  parameter int unsigned V_DISPLAY  = 1080,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned LOW_WATER  = 32
) (
  input  logic clk,
  input  logic reset,
  vga_fb_arbiter_if.slave bus
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0] underflow_cnt,
  output logic [15:0] wr_wait_cnt
`endif
);

  localparam int unsigned FRAME_PIX = H_DISPLAY * V_DISPLAY;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W     = PTR_W + 1;
  localparam int unsigned BCNT_W    = $clog2(BURST_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic LAST_WRITE = 1'b0;
  localparam logic LAST_FETCH = 1'b1;

  // FSM and access registers
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_fetch_en;
  logic [BCNT_W-1:0] r_burst_cnt;
  logic              r_last;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_wr_gnt;

  // FIFO registers
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_rd_pend;
  logic              r_underflow;

  // next-state wires
  logic [1:0]        w_nxt_state;
  logic [ADDR_W-1:0] w_nxt_rd_addr;
  logic              w_nxt_fetch_en;
  logic [BCNT_W-1:0] w_nxt_burst_cnt;
  logic              w_nxt_last;
  logic              w_nxt_mem_en;
  logic              w_nxt_mem_we;
  logic [ADDR_W-1:0] w_nxt_mem_addr;
  logic [DATA_W-1:0] w_nxt_mem_wdata;
  logic              w_nxt_wr_gnt;
  logic              w_issue_rd;

  logic w_room;
  logic w_low;
  logic w_need_fetch;
  logic w_push;
  logic w_pop_req;
  logic w_pop;
  logic w_empty_pop;

  // Fetch eligibility: only the read whose data is on the bus can still be in flight in IDLE
  assign w_room       = (32'(r_level) + 32'(r_rd_pend) + BURST_LEN) <= FIFO_DEPTH;
  assign w_low        = 32'(r_level) < LOW_WATER;
  assign w_need_fetch = r_fetch_en && w_room;

  // FIFO handshakes; a frame restart flushes and suppresses both push and pop
  assign w_push      = r_rd_pend && !bus.frame_start;
  assign w_pop_req   = bus.pix_rd && !bus.frame_start;
  assign w_pop       = w_pop_req && (r_level != '0);
  assign w_empty_pop = w_pop_req && (r_level == '0);

  // Next-state and next-access decode; the chosen access is issued next cycle from registers
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_rd_addr   = r_rd_addr;
    w_nxt_fetch_en  = r_fetch_en;
    w_nxt_burst_cnt = r_burst_cnt;
    w_nxt_last      = r_last;
    w_nxt_mem_en    = 1'b0;
    w_nxt_mem_we    = 1'b0;
    w_nxt_mem_addr  = '0;
    w_nxt_mem_wdata = '0;
    w_nxt_wr_gnt    = 1'b0;
    w_issue_rd      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_need_fetch && (w_low || !bus.wr_req || (r_last == LAST_WRITE))) begin
          w_nxt_state     = S_FETCH;
          w_nxt_burst_cnt = BCNT_W'(1);
          w_issue_rd      = 1'b1;
        end else if (bus.wr_req) begin
          w_nxt_state     = S_WRITE;
          w_nxt_mem_en    = 1'b1;
          w_nxt_mem_we    = 1'b1;
          w_nxt_mem_addr  = bus.wr_addr;
          w_nxt_mem_wdata = bus.wr_data;
          w_nxt_wr_gnt    = 1'b1;
        end
      end
      S_FETCH: begin
        // fetch_en already dropped means the frame's last pixel is being read now
        if ((r_burst_cnt == BCNT_W'(BURST_LEN)) || !r_fetch_en) begin
          w_nxt_state = S_IDLE;
          w_nxt_last  = LAST_FETCH;
        end else begin
          w_nxt_burst_cnt = r_burst_cnt + BCNT_W'(1);
          w_issue_rd      = 1'b1;
        end
      end
      S_WRITE: begin
        w_nxt_state = S_IDLE;
        w_nxt_last  = LAST_WRITE;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase

    if (w_issue_rd) begin
      w_nxt_mem_en   = 1'b1;
      w_nxt_mem_addr = r_rd_addr;
      if (r_rd_addr == ADDR_W'(FRAME_PIX - 1)) begin
        w_nxt_rd_addr  = '0;
        w_nxt_fetch_en = 1'b0;
      end else begin
        w_nxt_rd_addr = r_rd_addr + ADDR_W'(1);
      end
    end

    if (bus.frame_start) begin
      w_nxt_state     = S_IDLE;
      w_nxt_rd_addr   = '0;
      w_nxt_fetch_en  = 1'b1;
      w_nxt_burst_cnt = '0;
      w_nxt_mem_en    = 1'b0;
      w_nxt_mem_we    = 1'b0;
      w_nxt_mem_addr  = '0;
      w_nxt_mem_wdata = '0;
      w_nxt_wr_gnt    = 1'b0;
    end
  end

  // FSM state and RAM access registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rd_addr   <= '0;
      r_fetch_en  <= 1'b0;
      r_burst_cnt <= '0;
      r_last      <= LAST_WRITE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wr_gnt    <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_rd_addr   <= w_nxt_rd_addr;
      r_fetch_en  <= w_nxt_fetch_en;
      r_burst_cnt <= w_nxt_burst_cnt;
      r_last      <= w_nxt_last;
      r_mem_en    <= w_nxt_mem_en;
      r_mem_we    <= w_nxt_mem_we;
      r_mem_addr  <= w_nxt_mem_addr;
      r_mem_wdata <= w_nxt_mem_wdata;
      r_wr_gnt    <= w_nxt_wr_gnt;
    end
  end

  // FIFO pointers, level, read-return tracking and sticky underflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_rd_pend   <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.frame_start) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= r_mem_en && !r_mem_we;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (w_empty_pop) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // FIFO storage; cleared on reset so the head reads zero before the first fill
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.mem_rdata;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] r_underflow_cnt;
  logic [15:0] r_wr_wait_cnt;

  // Saturating counts of empty pops and writer stall cycles
  always_ff @(posedge clk) begin
    if (!reset || bus.frame_start) begin
      r_underflow_cnt <= '0;
      r_wr_wait_cnt   <= '0;
    end else begin
      if (w_empty_pop && (r_underflow_cnt != 16'hFFFF)) begin
        r_underflow_cnt <= r_underflow_cnt + 16'd1;
      end
      if (bus.wr_req && !r_wr_gnt && (r_wr_wait_cnt != 16'hFFFF)) begin
        r_wr_wait_cnt <= r_wr_wait_cnt + 16'd1;
      end
    end
  end

  assign underflow_cnt = r_underflow_cnt;
  assign wr_wait_cnt   = r_wr_wait_cnt;
`endif

  assign bus.pix_valid = (r_level != '0);
  assign bus.pix_data  = r_fifo[r_rd_ptr];
  assign bus.underflow = r_underflow;
  assign bus.wr_gnt    = r_wr_gnt;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed bench for vga_fb_arbiter with a small preloaded RAM
// model (mem[a] = a). Define FB_ARB_STATS_EN to also exercise the statistics outputs.
module tb_vga_fb_arbiter;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned H_DISPLAY  = 8;
  localparam int unsigned V_DISPLAY  = 2;
  localparam int unsigned BURST_LEN  = 4;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned LOW_WATER  = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   got;
  int   nreads;
  int   wait_c;
  logic exp_en;
  logic [31:0] exp_addr;

  logic [DATA_W-1:0] ram [64];

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef FB_ARB_STATS_EN
  logic [15:0] underflow_cnt;
  logic [15:0] wr_wait_cnt;
`endif

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_DISPLAY(H_DISPLAY), .V_DISPLAY(V_DISPLAY),
    .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .LOW_WATER(LOW_WATER)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FB_ARB_STATS_EN
    ,
    .underflow_cnt(underflow_cnt),
    .wr_wait_cnt(wr_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Single-port RAM model, read data one cycle after issue
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= DATA_W'(i);
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_rd = 1'b0;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // reset state
    cyc(2);
    check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    check("rst_pix_data",  32'(bus.pix_data),  32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
    check("rst_wr_gnt",    32'(bus.wr_gnt),    32'd0);
    check("rst_mem_en",    32'(bus.mem_en),    32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
`ifdef FB_ARB_STATS_EN
    check("rst_uf_cnt", 32'(underflow_cnt), 32'd0);
    check("rst_ww_cnt", 32'(wr_wait_cnt),   32'd0);
`endif
    reset = 1'b1;

    // 1: no frame_start, no activity
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      check("t1_mem_en",    32'(bus.mem_en),    32'd0);
      check("t1_pix_valid", 32'(bus.pix_valid), 32'd0);
    end

    // 2: two bursts 0-3 and 4-7 then idle with full FIFO
    bus.frame_start = 1'b1;
    cyc(1);
    bus.frame_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      exp_en   = ((c >= 2) && (c <= 5)) || ((c >= 7) && (c <= 10));
      exp_addr = (c <= 5) ? 32'(c - 2) : 32'(c - 3);
      check("t2_mem_en", 32'(bus.mem_en), 32'(exp_en));
      if (exp_en) begin
        check("t2_mem_addr", 32'(bus.mem_addr), exp_addr);
        check("t2_mem_we",   32'(bus.mem_we),   32'd0);
      end
      cyc(1);
    end
    check("t2_pix_valid", 32'(bus.pix_valid), 32'd1);
    check("t2_pix_data",  32'(bus.pix_data),  32'd0);

    // 3: drain a whole frame, fetch stops after pixel 15, then empty pop
    bus.frame_start = 1'b1;
    cyc(1);
    bus.frame_start = 1'b0;
    got = 0;
    nreads = 0;
    for (int c = 0; c < 150; c++) begin
      if (bus.mem_en) nreads++;
      if (bus.pix_valid && (got < 16)) begin
        check("t3_pix_data", 32'(bus.pix_data), 32'(got));
        bus.pix_rd = 1'b1;
        got++;
      end else begin
        bus.pix_rd = 1'b0;
      end
      cyc(1);
    end
    bus.pix_rd = 1'b0;
    check("t3_pops",      32'(got),           32'd16);
    check("t3_reads",     32'(nreads),        32'd16);
    check("t3_pix_valid", 32'(bus.pix_valid), 32'd0);
    check("t3_uf_before", 32'(bus.underflow), 32'd0);
    bus.pix_rd = 1'b1;
    cyc(1);
    bus.pix_rd = 1'b0;
    check("t3_uf_after",  32'(bus.underflow), 32'd1);

    // 4: writer held from cycle 1; granted once the FIFO has no room
    bus.frame_start = 1'b1;
    cyc(1);
    bus.frame_start = 1'b0;
    bus.wr_req  = 1'b1;
    bus.wr_addr = ADDR_W'(20);
    bus.wr_data = 24'hABCDEF;
    wait_c = 0;
    while (!bus.wr_gnt && (wait_c < 40)) begin
      cyc(1);
      wait_c++;
    end
    check("t4_gnt_latency", 32'(wait_c),        32'd11);
    check("t4_gnt",         32'(bus.wr_gnt),    32'd1);
    check("t4_mem_en",      32'(bus.mem_en),    32'd1);
    check("t4_mem_we",      32'(bus.mem_we),    32'd1);
    check("t4_mem_addr",    32'(bus.mem_addr),  32'd20);
    check("t4_mem_wdata",   32'(bus.mem_wdata), 32'hABCDEF);
    bus.wr_req = 1'b0;
    cyc(1);
    check("t4_gnt_pulse",   32'(bus.wr_gnt),    32'd0);
    check("t4_mem_we_off",  32'(bus.mem_we),    32'd0);
    check("t4_ram20",       32'(ram[20]),       32'hABCDEF);

    // 5: restart in the middle of the second burst
    bus.frame_start = 1'b1;
    cyc(1);
    bus.frame_start = 1'b0;
    wait_c = 0;
    while (!(bus.mem_en && (bus.mem_addr == ADDR_W'(5))) && (wait_c < 40)) begin
      cyc(1);
      wait_c++;
    end
    check("t5_found_addr5", 32'(bus.mem_addr), 32'd5);
    bus.frame_start = 1'b1;
    cyc(1);
    bus.frame_start = 1'b0;
    check("t5_flushed",  32'(bus.pix_valid), 32'd0);
    check("t5_mem_idle", 32'(bus.mem_en),    32'd0);
    wait_c = 0;
    while (!bus.mem_en && (wait_c < 10)) begin
      cyc(1);
      wait_c++;
    end
    check("t5_restart_en",   32'(bus.mem_en),   32'd1);
    check("t5_restart_addr", 32'(bus.mem_addr), 32'd0);
    got = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.pix_valid && (got < 6)) begin
        check("t5_pix_data", 32'(bus.pix_data), 32'(got));
        bus.pix_rd = 1'b1;
        got++;
      end else begin
        bus.pix_rd = 1'b0;
      end
      cyc(1);
    end
    bus.pix_rd = 1'b0;
    check("t5_pops", 32'(got), 32'd6);

`ifdef FB_ARB_STATS_EN
    // 6: three empty pops, then a writer stalled behind one burst
    bus.frame_start = 1'b1;
    cyc(1);
    bus.frame_start = 1'b0;
    check("t6_uf_clr", 32'(underflow_cnt), 32'd0);
    check("t6_ww_clr", 32'(wr_wait_cnt),   32'd0);
    bus.pix_rd = 1'b1;
    cyc(3);
    bus.pix_rd = 1'b0;
    check("t6_uf_cnt", 32'(underflow_cnt), 32'd3);
    cyc(30);
    check("t6_full", 32'(bus.pix_valid), 32'd1);
    bus.pix_rd = 1'b1;
    cyc(4);
    bus.pix_rd = 1'b0;
    check("t6_decide_idle", 32'(bus.mem_en), 32'd0);
    cyc(1);
    bus.wr_req  = 1'b1;
    bus.wr_addr = ADDR_W'(30);
    bus.wr_data = 24'h123456;
    check("t6_fetch_en",   32'(bus.mem_en),   32'd1);
    check("t6_fetch_addr", 32'(bus.mem_addr), 32'd8);
    wait_c = 0;
    while (!bus.wr_gnt && (wait_c < 20)) begin
      cyc(1);
      wait_c++;
    end
    check("t6_gnt_latency", 32'(wait_c), 32'd5);
    bus.wr_req = 1'b0;
    cyc(1);
    check("t6_ww_cnt", 32'(wr_wait_cnt),   32'd5);
    check("t6_uf_cnt_hold", 32'(underflow_cnt), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
